// File: rtl/seven_seg_scanner_if.sv
// Bundle between the watch controller and the seven-segment scanner:
// image load request, live blink mask, and the decoder/digit drive
// returned by the scanner.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
) ();

    // Controller -> scanner
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_values;
    logic [NUM_DIGITS-1:0]     load_modes;
    logic [NUM_DIGITS-1:0]     blink_mask;

    // Scanner -> decoder / digit drivers / controller
    logic [3:0]                dec_value;
    logic                      dec_mode;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      frame_start;
    logic                      load_ack;

    // Controller side
    modport master (
        output load, load_values, load_modes, blink_mask,
        input  dec_value, dec_mode, digit_en, frame_start, load_ack
    );

    // Scanner side
    modport slave (
        input  load, load_values, load_modes, blink_mask,
        output dec_value, dec_mode, digit_en, frame_start, load_ack
    );

endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner. Each digit slot is a blanking
// period followed by a drive period; a frame is NUM_DIGITS slots. The
// displayed image is double-buffered and only swapped at the frame
// boundary so the display never tears. Per-digit blinking gates the
// digit enable on alternate groups of BLINK_DIV frames.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_seg_scanner_if.slave   bus
);

    // Slot counter must hold the longer of the two phase lengths.
    localparam int MAX_PHASE = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W      = $clog2(BLINK_DIV + 1);
    localparam int VAL_W     = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BLINK_WRAP = BC_W'(BLINK_DIV);

    // Blank image: every digit shows ALPHABET code 0 (space).
    localparam logic [VAL_W-1:0]      BLANK_VALUES = '0;
    localparam logic [NUM_DIGITS-1:0] BLANK_MODES  = '1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Scan state
    state_t                  state_q,       state_d;
    logic [IDX_W-1:0]        idx_q,         idx_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic [BC_W-1:0]         blink_cnt_q,   blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    // Double-buffered image
    logic [VAL_W-1:0]        act_val_q,     act_val_d;
    logic [NUM_DIGITS-1:0]   act_mode_q,    act_mode_d;
    logic [VAL_W-1:0]        pend_val_q,    pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_mode_q,   pend_mode_d;
    logic                    pend_q,        pend_d;

    // Registered outputs
    logic [3:0]              dec_value_q,   dec_value_d;
    logic                    dec_mode_q,    dec_mode_d;
    logic [NUM_DIGITS-1:0]   digit_en_q,    digit_en_d;
    logic                    frame_start_q, frame_start_d;
    logic                    load_ack_q,    load_ack_d;

    logic                    phase_done;
    logic                    frame_wrap;
    logic [BC_W-1:0]         blink_inc;

    // Next-state, buffer commit/load and registered output values.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        act_val_d     = act_val_q;
        act_mode_d    = act_mode_q;
        pend_val_d    = pend_val_q;
        pend_mode_d   = pend_mode_q;
        pend_d        = pend_q;
        dec_value_d   = 4'd0;
        dec_mode_d    = 1'b1;
        digit_en_d    = '0;
        frame_start_d = 1'b0;
        load_ack_d    = 1'b0;
        frame_wrap    = 1'b0;
        blink_inc     = blink_cnt_q + 1'b1;

        phase_done = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST)
                                           : (cnt_q == DRIVE_LAST);

        // Slot sequencing: BLANK -> DRIVE on the same digit, DRIVE -> BLANK
        // on the next digit, wrapping after the last digit.
        if (!phase_done) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_DRIVE;
            end else begin
                state_d = ST_BLANK;
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        // Frame boundary: announce the frame, commit any pending image and
        // advance the blink schedule.
        if (frame_wrap) begin
            frame_start_d = 1'b1;
            if (pend_q) begin
                act_val_d  = pend_val_q;
                act_mode_d = pend_mode_q;
                pend_d     = 1'b0;
                load_ack_d = 1'b1;
            end
            if (blink_inc == BLINK_WRAP) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_inc;
            end
        end

        // A load on the commit edge lands after the commit above, so it
        // waits for the next frame rather than being lost.
        if (bus.load) begin
            pend_val_d  = bus.load_values;
            pend_mode_d = bus.load_modes;
            pend_d      = 1'b1;
        end

        // Drive values for the state being entered; a blinked-off digit
        // keeps its value on the decoder but its enable stays low.
        if (state_d == ST_DRIVE) begin
            dec_value_d = act_val_d[4*idx_d +: 4];
            dec_mode_d  = act_mode_d[idx_d];
            digit_en_d[idx_d] = ~(blink_phase_d & bus.blink_mask[idx_d]);
        end
    end

    // State, buffer and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            // NOTE: the image buffers are plain flops, not RAM, so they are
            // reset to the blank image and the display starts clean.
            act_val_q     <= BLANK_VALUES;
            act_mode_q    <= BLANK_MODES;
            pend_val_q    <= BLANK_VALUES;
            pend_mode_q   <= BLANK_MODES;
            pend_q        <= 1'b0;
            dec_value_q   <= 4'd0;
            dec_mode_q    <= 1'b1;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            act_val_q     <= act_val_d;
            act_mode_q    <= act_mode_d;
            pend_val_q    <= pend_val_d;
            pend_mode_q   <= pend_mode_d;
            pend_q        <= pend_d;
            dec_value_q   <= dec_value_d;
            dec_mode_q    <= dec_mode_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
        end
    end

    assign bus.dec_value   = dec_value_q;
    assign bus.dec_mode    = dec_mode_q;
    assign bus.digit_en    = digit_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.load_ack    = load_ack_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios from the
// test plan followed by randomized loads, blink masks and resets, all
// checked every cycle against a time-based reference model.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int BD    = 2;
    localparam int SLOT  = BC + SD;
    localparam int FRAME = ND * SLOT;

    logic clk;
    logic reset;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_DIV    (BD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since the last reset edge plus the two images.
    int         m_t;
    logic [3:0] m_act_val  [ND];
    logic       m_act_mode [ND];
    logic [3:0] m_pend_val [ND];
    logic       m_pend_mode[ND];
    bit         m_pend;

    logic [3:0] cur_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on
    // the following falling edge.
    task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] m,
                         input logic [3:0] msk, input bit rst);
        bit         e_fs, e_ack, phase;
        int         tf, digit, pos;
        logic [3:0] e_val, e_en;
        logic       e_mode;
        reset               = rst;
        bus.load            = ld;
        bus.load_values     = v;
        bus.load_modes      = m;
        bus.blink_mask      = msk;
        @(posedge clk);
        e_fs  = 1'b0;
        e_ack = 1'b0;
        if (rst) begin
            m_t    = 0;
            m_pend = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_act_val[i]   = 4'd0;
                m_act_mode[i]  = 1'b1;
                m_pend_val[i]  = 4'd0;
                m_pend_mode[i] = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                e_fs = 1'b1;
                if (m_pend) begin
                    e_ack  = 1'b1;
                    m_pend = 1'b0;
                    for (int i = 0; i < ND; i++) begin
                        m_act_val[i]  = m_pend_val[i];
                        m_act_mode[i] = m_pend_mode[i];
                    end
                end
            end
            if (ld) begin
                m_pend = 1'b1;
                for (int i = 0; i < ND; i++) begin
                    m_pend_val[i]  = v[4*i +: 4];
                    m_pend_mode[i] = m[i];
                end
            end
        end
        tf    = m_t % FRAME;
        digit = tf / SLOT;
        pos   = tf % SLOT;
        phase = ((m_t / FRAME) / BD) % 2 == 1;
        if (pos >= BC) begin
            e_val  = m_act_val[digit];
            e_mode = m_act_mode[digit];
            e_en   = (phase && msk[digit]) ? 4'b0000 : 4'(1 << digit);
        end else begin
            e_val  = 4'd0;
            e_mode = 1'b1;
            e_en   = 4'b0000;
        end
        @(negedge clk);
        check("dec_value",   32'(bus.dec_value),   32'(e_val));
        check("dec_mode",    32'(bus.dec_mode),    32'(e_mode));
        check("digit_en",    32'(bus.digit_en),    32'(e_en));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("load_ack",    32'(bus.load_ack),    32'(e_ack));
    endtask

    task automatic idle(input bit rst);
        cycle(1'b0, 16'h0, 4'h0, cur_mask, rst);
    endtask

    logic [15:0] rv;
    logic [3:0]  rm;

    initial begin
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.load_values = '0;
        bus.load_modes = '0;
        bus.blink_mask = '0;
        cur_mask       = 4'b0000;
        m_t            = 0;

        // 1: free-running scan of the blank image.
        idle(1'b1); idle(1'b1);
        for (int c = 1; c <= 30; c++) idle(1'b0);

        // 2: load 1,2,3,4 / NUMBER at cycle 5, committed at cycle 24.
        idle(1'b1);
        for (int c = 1; c <= 40; c++)
            cycle(c == 5, 16'h4321, 4'b0000, cur_mask, 1'b0);

        // 3: two loads in one frame, only the later one is shown.
        idle(1'b1);
        for (int c = 1; c <= 50; c++) begin
            if (c == 10)      cycle(1'b1, 16'hAAAA, 4'b1010, cur_mask, 1'b0);
            else if (c == 20) cycle(1'b1, 16'hB5B5, 4'b0101, cur_mask, 1'b0);
            else              idle(1'b0);
        end

        // 4: loads just before and exactly on the commit edge.
        idle(1'b1);
        for (int c = 1; c <= 80; c++) begin
            if (c == 23)      cycle(1'b1, 16'h1A2B, 4'b0011, cur_mask, 1'b0);
            else if (c == 47) cycle(1'b1, 16'h3C4D, 4'b1100, cur_mask, 1'b0);
            else if (c == 48) cycle(1'b1, 16'h5E6F, 4'b0110, cur_mask, 1'b0);
            else              idle(1'b0);
        end

        // 5: blink digit 2 across frames 0..4.
        idle(1'b1);
        cycle(1'b1, 16'h9876, 4'b0000, cur_mask, 1'b0);
        cur_mask = 4'b0100;
        for (int c = 2; c <= 5 * FRAME + 5; c++) idle(1'b0);
        cur_mask = 4'b0000;

        // 6: reset with a load pending discards it.
        idle(1'b1);
        for (int c = 1; c <= 14; c++)
            cycle(c == 8, 16'hFEDC, 4'b1111, cur_mask, 1'b0);
        idle(1'b1);
        for (int c = 1; c <= 60; c++) idle(1'b0);

        // Randomized traffic.
        idle(1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) cur_mask = 4'($urandom);
            rv = 16'($urandom);
            rm = 4'($urandom);
            cycle($urandom_range(0, 15) == 0, rv, rm, cur_mask,
                  $urandom_range(0, 799) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexes NUM_DIGITS display digits through one shared SevenSegDecoder instance in the watch controller.
- Holds a double-buffered digit and mode image, and drives the decoder's value/mode inputs plus one-hot digit enables.
- Inserts inter-digit blanking to suppress ghosting.
- Supports per-digit blinking for the watch's set-time screens.
- Loads from the controller are committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- SCAN_DIV, 1000: clock cycles each digit is driven.
- BLANK_CYCLES, 16: clock cycles of blanking before each digit's drive period (>=1).
- BLINK_DIV, 64: frames per blink half-period (>=1).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle request to write a new display image.
- load_values  input  4*NUM_DIGITS  digit codes; digit i = bits [4i+3:4i].
- load_modes  input  NUM_DIGITS  per-digit decoder mode; 0 = NUMBER, 1 = ALPHABET.
- blink_mask  input  NUM_DIGITS  digits to blink; sampled live, not buffered.
- dec_value  output  4  value input of the decoder.
- dec_mode  output  1  mode input of the decoder.
- digit_en  output  NUM_DIGITS  one-hot, active-high digit enable.
- frame_start  output  1  one-cycle pulse at start of each frame after the first.
- load_ack  output  1  one-cycle pulse when the pending image is committed.

Behaviour:
- Reset (synchronous, active-high; all state registered):
  - Outputs: dec_value=0, dec_mode=1 (ALPHABET C_SPACE), digit_en=0, frame_start=0, load_ack=0.
  - State: BLANK, digit index 0, slot counter 0, blink phase 0, pending flag 0.
  - Buffers: active and pending buffers all values 0 and modes 1, i.e. blank display.
- Reset mid-frame aborts the scan immediately. Any pending load is discarded and not acked.
- FSM states: BLANK and DRIVE; the slot counter counts cycles within the current state.
  - BLANK: lasts BLANK_CYCLES cycles. digit_en=0, dec_value=0, dec_mode=1. Then go to DRIVE for the same digit.
  - DRIVE: lasts SCAN_DIV cycles. dec_value and dec_mode = active buffer entry for the current digit index. digit_en[idx]=1, except forced 0 when blink phase=1 and blink_mask[idx]=1. dec_value/dec_mode still present the digit in that case.
  - DRIVE exit: go to BLANK of idx+1. From idx=NUM_DIGITS-1, wrap to idx 0; this is the frame boundary.
- Timing: one slot = BLANK_CYCLES+SCAN_DIV cycles; one frame = NUM_DIGITS slots.
  - All outputs are registered and change on the clock edge that enters the state.
  - Reset deasserted at edge 0 means the first BLANK cycle of digit 0 is cycle 0.
- Frame boundary, on the edge entering BLANK of digit 0:
  - frame_start=1 for that one cycle. It does not pulse on the first frame after reset.
  - If the pending flag is set: copy pending to active, clear the flag, load_ack=1 in the same cycle as frame_start.
  - Blink frame counter increments; at BLINK_DIV it clears and blink phase toggles.
- Load handling:
  - load=1 captures load_values/load_modes into the pending buffer and sets the pending flag.
  - Repeated loads before a commit overwrite pending; the latest wins, and only one ack is given.
  - Load in the same cycle as the commit edge: the commit uses the pending contents from before that edge. The new data goes into pending, and the flag stays 1 for the next frame.
  - Load values are unrestricted 4-bit codes; decoder interpretation is mode-dependent.
- The active buffer changes only at frame boundaries; blink_mask may change any cycle and takes effect next cycle.
- At most one digit_en bit is high in any cycle; digit_en never goes high in BLANK.

Test Plan:
Common parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2, BLINK_DIV=2 (slot = 6 cycles, frame = 24 cycles).
1. Reset, then hold 30 cycles -> cycles 0-1 have digit_en=0; cycles 2-5 have digit_en=0001, dec_value=0, dec_mode=1; digit_en=0010 at cycles 8-11; no frame_start or load_ack at cycle 0; frame_start only at cycle 24.
2. Load at cycle 5 with values 4'h1,2,3,4 (digit0 first) and modes 0000 -> frame 0 still shows 0/ALPHABET; frame_start and load_ack both 1 at cycle 24; cycles 26-29 show dec_value=1, dec_mode=0, digit_en=0001; cycles 32-35 show dec_value=2.
3. Load A at cycle 10 and load B at cycle 20 -> a single load_ack at cycle 24, and frame 1 shows B.
4. Load A at cycle 23 (the pending flag is empty, so frame 1 displays A); then load B at cycle 47, immediately before the cycle-48 commit edge, and load C at cycle 48, on the commit edge -> frame 2 shows B with load_ack at cycle 48; C commits with load_ack at cycle 72.
5. blink_mask=0100 -> digit 2's digit_en is high in frames 0-1, low in frames 2-3, and high again in frame 4, while dec_value is still driven; other digits are unaffected.
6. Reset asserted at cycle 15 with a load pending -> the next cycle has all outputs at reset values; after release the display shows the blank image and no load_ack occurs.
